// File: rtl/custom_rv_core.sv
// rtl/custom_rv_core.sv - multi-cycle RV32I + Zicsr machine-mode core with Wishbone fetch and data ports
module custom_rv_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] iwb_adr_o,
  input  logic [31:0] iwb_dat_i,
  output logic        iwb_cyc_o,
  output logic        iwb_stb_o,
  input  logic        iwb_ack_i,
  output logic [31:0] dwb_adr_o,
  output logic [31:0] dwb_dat_o,
  input  logic [31:0] dwb_dat_i,
  output logic        dwb_we_o,
  output logic [3:0]  dwb_sel_o,
  output logic        dwb_cyc_o,
  output logic        dwb_stb_o,
  input  logic        dwb_ack_i,
  input  logic        dwb_err_i,
  input  logic [31:0] interrupts
);
  localparam logic [2:0] STATE_FETCH = 3'd0, STATE_DECODE = 3'd1, STATE_EXECUTE = 3'd2,
                         STATE_MEM = 3'd3, STATE_WRITEBACK = 3'd4, STATE_TRAP = 3'd5;
  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_BRANCH = 7'b1100011, OP_LOAD = 7'b0000011,
                         OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011,
                         OP_FENCE = 7'b0001111, OP_SYSTEM = 7'b1110011;

  logic [2:0]  r_state, w_next_state;
  logic        r_run;
  logic [31:0] r_pc, r_instr, r_rs1v, r_rs2v, r_imm, r_alu, r_target, r_mem_data;
  logic        r_taken;
  logic [31:0] r_rf [0:31];
  logic        r_mstatus_mie, r_mstatus_mpie;
  logic [31:0] r_mie, r_mtvec, r_mscratch, r_mepc, r_mcause, r_mtval;
  logic [31:0] r_trap_pc, r_trap_cause, r_trap_val;

  logic [6:0]  w_opcode, w_funct7;
  logic [4:0]  w_rd, w_rs1, w_rs2, w_irq_idx;
  logic [2:0]  w_funct3;
  logic [31:0] w_imm, w_op_a, w_op_b, w_alu, w_target, w_ld_shift, w_load_data;
  logic [31:0] w_csr_rdata, w_csr_src, w_csr_wdata, w_rd_data, w_next_pc, w_irq_pend;
  logic        w_illegal, w_ecall, w_ebreak, w_mret, w_taken, w_redirect;
  logic        w_mem_read, w_mem_write, w_is_csr, w_csr_we, w_rd_wen;
  logic        w_misal_mem, w_misal_tgt, w_irq;

  assign w_opcode    = r_instr[6:0];
  assign w_rd        = r_instr[11:7];
  assign w_funct3    = r_instr[14:12];
  assign w_rs1       = r_instr[19:15];
  assign w_rs2       = r_instr[24:20];
  assign w_funct7    = r_instr[31:25];
  assign w_mem_read  = (w_opcode == OP_LOAD);
  assign w_mem_write = (w_opcode == OP_STORE);
  assign w_is_csr    = (w_opcode == OP_SYSTEM) && (w_funct3 != 3'b000);

  // Decode: immediate format and legality of the latched instruction
  always_comb begin
    w_imm     = {{20{r_instr[31]}}, r_instr[31:20]};
    w_illegal = 1'b0;
    w_ecall   = 1'b0;
    w_ebreak  = 1'b0;
    w_mret    = 1'b0;
    case (w_opcode)
      OP_LUI, OP_AUIPC: w_imm = {r_instr[31:12], 12'b0};
      OP_JAL:    w_imm = {{11{r_instr[31]}}, r_instr[31], r_instr[19:12], r_instr[20], r_instr[30:21], 1'b0};
      OP_JALR:   w_illegal = (w_funct3 != 3'b000);
      OP_BRANCH: begin
        w_imm     = {{19{r_instr[31]}}, r_instr[31], r_instr[7], r_instr[30:25], r_instr[11:8], 1'b0};
        w_illegal = (w_funct3[2:1] == 2'b01);
      end
      OP_LOAD:   w_illegal = (w_funct3 == 3'b011) || (w_funct3[2:1] == 2'b11);
      OP_STORE: begin
        w_imm     = {{20{r_instr[31]}}, r_instr[31:25], r_instr[11:7]};
        w_illegal = w_funct3[2] || (w_funct3[1:0] == 2'b11);
      end
      OP_IMM:    w_illegal = ((w_funct3 == 3'b001) && (w_funct7 != 7'd0)) ||
                             ((w_funct3 == 3'b101) && (w_funct7 != 7'd0) && (w_funct7 != 7'b0100000));
      OP_REG:    w_illegal = !((w_funct7 == 7'd0) ||
                               ((w_funct7 == 7'b0100000) && ((w_funct3 == 3'b000) || (w_funct3 == 3'b101))));
      OP_FENCE:  w_illegal = 1'b0;
      OP_SYSTEM: begin
        if (w_funct3 == 3'b000) begin
          w_ecall   = (r_instr == 32'h0000_0073);
          w_ebreak  = (r_instr == 32'h0010_0073);
          w_mret    = (r_instr == 32'h3020_0073);
          w_illegal = !(w_ecall || w_ebreak || w_mret);
        end else begin
          w_illegal = (w_funct3 == 3'b100);
        end
      end
      default:   w_illegal = 1'b1;
    endcase
  end

  // Execute: ALU, branch compare and control-transfer target
  always_comb begin
    w_op_a = (w_opcode == OP_LUI) ? 32'd0 : (w_opcode == OP_AUIPC) ? r_pc : r_rs1v;
    w_op_b = ((w_opcode == OP_REG) || (w_opcode == OP_BRANCH)) ? r_rs2v : r_imm;
    w_alu  = w_op_a + w_op_b;
    if ((w_opcode == OP_REG) || (w_opcode == OP_IMM)) begin
      case (w_funct3)
        3'b000: w_alu = ((w_opcode == OP_REG) && w_funct7[5]) ? w_op_a - w_op_b : w_op_a + w_op_b;
        3'b001: w_alu = w_op_a << w_op_b[4:0];
        3'b010: w_alu = {31'd0, $signed(w_op_a) < $signed(w_op_b)};
        3'b011: w_alu = {31'd0, w_op_a < w_op_b};
        3'b100: w_alu = w_op_a ^ w_op_b;
        3'b101: w_alu = w_funct7[5] ? 32'($signed(w_op_a) >>> w_op_b[4:0]) : w_op_a >> w_op_b[4:0];
        3'b110: w_alu = w_op_a | w_op_b;
        default: w_alu = w_op_a & w_op_b;
      endcase
    end
    case (w_funct3)
      3'b000:  w_taken = (r_rs1v == r_rs2v);
      3'b001:  w_taken = (r_rs1v != r_rs2v);
      3'b100:  w_taken = ($signed(r_rs1v) < $signed(r_rs2v));
      3'b101:  w_taken = ($signed(r_rs1v) >= $signed(r_rs2v));
      3'b110:  w_taken = (r_rs1v < r_rs2v);
      default: w_taken = (r_rs1v >= r_rs2v);
    endcase
    w_target    = (w_opcode == OP_JALR) ? ((r_rs1v + r_imm) & ~32'd1) : (r_pc + r_imm);
    w_redirect  = (w_opcode == OP_JAL) || (w_opcode == OP_JALR) || ((w_opcode == OP_BRANCH) && w_taken);
    w_misal_tgt = w_redirect && (w_target[1:0] != 2'b00);
    w_misal_mem = (w_mem_read || w_mem_write) &&
                  (((w_funct3[1:0] == 2'b01) && w_alu[0]) || ((w_funct3[1:0] == 2'b10) && (w_alu[1:0] != 2'b00)));
  end

  // CSR read mux and read-modify-write value
  always_comb begin
    case (r_instr[31:20])
      12'h300: w_csr_rdata = {24'd0, r_mstatus_mpie, 3'd0, r_mstatus_mie, 3'd0};
      12'h304: w_csr_rdata = r_mie;
      12'h305: w_csr_rdata = r_mtvec;
      12'h340: w_csr_rdata = r_mscratch;
      12'h341: w_csr_rdata = r_mepc;
      12'h342: w_csr_rdata = r_mcause;
      12'h343: w_csr_rdata = r_mtval;
      12'h344: w_csr_rdata = interrupts;
      default: w_csr_rdata = 32'd0;
    endcase
    w_csr_src = w_funct3[2] ? {27'd0, w_rs1} : r_rs1v;
    case (w_funct3[1:0])
      2'b01:   w_csr_wdata = w_csr_src;
      2'b10:   w_csr_wdata = w_csr_rdata | w_csr_src;
      2'b11:   w_csr_wdata = w_csr_rdata & ~w_csr_src;
      default: w_csr_wdata = w_csr_rdata;
    endcase
    w_csr_we = w_is_csr && ((w_funct3[1:0] == 2'b01) || (w_rs1 != 5'd0));
  end

  // Writeback value selection, load alignment and next pc
  always_comb begin
    w_ld_shift = r_mem_data >> {r_alu[1:0], 3'b000};
    case (w_funct3)
      3'b000:  w_load_data = {{24{w_ld_shift[7]}}, w_ld_shift[7:0]};
      3'b001:  w_load_data = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
      3'b100:  w_load_data = {24'd0, w_ld_shift[7:0]};
      3'b101:  w_load_data = {16'd0, w_ld_shift[15:0]};
      default: w_load_data = r_mem_data;
    endcase
    if (w_mem_read)                                       w_rd_data = w_load_data;
    else if ((w_opcode == OP_JAL) || (w_opcode == OP_JALR)) w_rd_data = r_pc + 32'd4;
    else if (w_is_csr)                                    w_rd_data = w_csr_rdata;
    else                                                  w_rd_data = r_alu;
    w_rd_wen = (w_rd != 5'd0) && (w_mem_read || w_is_csr || (w_opcode == OP_LUI) || (w_opcode == OP_AUIPC) ||
               (w_opcode == OP_JAL) || (w_opcode == OP_JALR) || (w_opcode == OP_REG) || (w_opcode == OP_IMM));
    w_next_pc = r_taken ? r_target : w_mret ? r_mepc : r_pc + 32'd4;
  end

  // Pending enabled interrupt with the lowest index wins
  always_comb begin
    w_irq_pend = interrupts & r_mie;
    w_irq_idx  = 5'd0;
    for (int i = 31; i >= 0; i--) if (w_irq_pend[i]) w_irq_idx = 5'(i);
    w_irq = r_mstatus_mie && (w_irq_pend != 32'd0);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= STATE_FETCH;
    else        r_state <= w_next_state;
  end

  // Next-state logic; interrupts are taken on the way back to FETCH
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      STATE_FETCH:     if (iwb_cyc_o && iwb_ack_i) w_next_state = STATE_DECODE;
      STATE_DECODE:    w_next_state = (w_illegal || w_ecall || w_ebreak) ? STATE_TRAP : STATE_EXECUTE;
      STATE_EXECUTE:   w_next_state = (w_misal_tgt || w_misal_mem) ? STATE_TRAP :
                                      (w_mem_read || w_mem_write) ? STATE_MEM : STATE_WRITEBACK;
      STATE_MEM:       if (dwb_err_i) w_next_state = STATE_TRAP;
                       else if (dwb_ack_i) w_next_state = STATE_WRITEBACK;
      STATE_WRITEBACK: w_next_state = w_irq ? STATE_TRAP : STATE_FETCH;
      default:         w_next_state = STATE_FETCH;
    endcase
  end

  // Bus outputs decoded from state; the fetch port idles for one cycle after reset release
  always_comb begin
    iwb_adr_o = r_pc;
    iwb_cyc_o = r_run && (r_state == STATE_FETCH);
    iwb_stb_o = iwb_cyc_o;
    dwb_adr_o = 32'd0;
    dwb_dat_o = 32'd0;
    dwb_we_o  = 1'b0;
    dwb_sel_o = 4'd0;
    dwb_cyc_o = 1'b0;
    dwb_stb_o = 1'b0;
    if (r_state == STATE_MEM) begin
      dwb_cyc_o = 1'b1;
      dwb_stb_o = 1'b1;
      dwb_adr_o = r_alu;
      dwb_sel_o = 4'hF;
      if (w_mem_write) begin
        dwb_we_o = 1'b1;
        case (w_funct3[1:0])
          2'b00:   begin dwb_dat_o = {4{r_rs2v[7:0]}};  dwb_sel_o = 4'b0001 << r_alu[1:0]; end
          2'b01:   begin dwb_dat_o = {2{r_rs2v[15:0]}}; dwb_sel_o = 4'b0011 << r_alu[1:0]; end
          default: dwb_dat_o = r_rs2v;
        endcase
      end
    end
  end

  // Datapath, register file, CSRs and trap bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0; r_pc <= RESET_PC; r_instr <= 32'd0; r_rs1v <= 32'd0; r_rs2v <= 32'd0;
      r_imm <= 32'd0; r_alu <= 32'd0; r_target <= 32'd0; r_taken <= 1'b0; r_mem_data <= 32'd0;
      for (int i = 0; i < 32; i++) r_rf[i] <= 32'd0;
      r_mstatus_mie <= 1'b0; r_mstatus_mpie <= 1'b0; r_mie <= 32'd0; r_mtvec <= 32'd0;
      r_mscratch <= 32'd0; r_mepc <= 32'd0; r_mcause <= 32'd0; r_mtval <= 32'd0;
      r_trap_pc <= 32'd0; r_trap_cause <= 32'd0; r_trap_val <= 32'd0;
    end else begin
      r_run <= 1'b1;
      case (r_state)
        STATE_FETCH: if (iwb_cyc_o && iwb_ack_i) r_instr <= iwb_dat_i;
        STATE_DECODE: begin
          r_rs1v <= r_rf[w_rs1];
          r_rs2v <= r_rf[w_rs2];
          r_imm  <= w_imm;
          r_trap_pc <= r_pc;
          if (w_illegal)     begin r_trap_cause <= 32'd2;  r_trap_val <= r_instr; end
          else if (w_ecall)  begin r_trap_cause <= 32'd11; r_trap_val <= 32'd0;   end
          else if (w_ebreak) begin r_trap_cause <= 32'd3;  r_trap_val <= 32'd0;   end
        end
        STATE_EXECUTE: begin
          r_alu     <= w_alu;
          r_target  <= w_target;
          r_taken   <= w_redirect;
          r_trap_pc <= r_pc;
          if (w_misal_tgt) begin
            r_trap_cause <= 32'd0;
            r_trap_val   <= w_target;
          end else if (w_misal_mem) begin
            r_trap_cause <= w_mem_read ? 32'd4 : 32'd6;
            r_trap_val   <= w_alu;
          end
        end
        STATE_MEM: begin
          if (dwb_err_i) begin
            r_trap_pc    <= r_pc;
            r_trap_cause <= w_mem_read ? 32'd5 : 32'd7;
            r_trap_val   <= r_alu;
          end else if (dwb_ack_i) begin
            r_mem_data <= dwb_dat_i;
          end
        end
        STATE_WRITEBACK: begin
          if (w_rd_wen) r_rf[w_rd] <= w_rd_data;
          if (w_csr_we) begin
            case (r_instr[31:20])
              12'h300: begin r_mstatus_mie <= w_csr_wdata[3]; r_mstatus_mpie <= w_csr_wdata[7]; end
              12'h304: r_mie      <= w_csr_wdata;
              12'h305: r_mtvec    <= w_csr_wdata;
              12'h340: r_mscratch <= w_csr_wdata;
              12'h341: r_mepc     <= {w_csr_wdata[31:2], 2'b00};
              12'h342: r_mcause   <= w_csr_wdata;
              12'h343: r_mtval    <= w_csr_wdata;
              default: ;
            endcase
          end
          if (w_mret) begin
            r_mstatus_mie  <= r_mstatus_mpie;
            r_mstatus_mpie <= 1'b1;
          end
          r_pc <= w_next_pc;
          if (w_irq) begin
            r_trap_pc    <= w_next_pc;
            r_trap_cause <= {1'b1, 26'd0, w_irq_idx};
            r_trap_val   <= 32'd0;
          end
        end
        STATE_TRAP: begin
          r_mepc         <= r_trap_pc;
          r_mcause       <= r_trap_cause;
          r_mtval        <= r_trap_val;
          r_mstatus_mpie <= r_mstatus_mie;
          r_mstatus_mie  <= 1'b0;
          r_pc           <= {r_mtvec[31:2], 2'b00};
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_custom_rv_core.sv
// tb/tb_custom_rv_core.sv - directed program bench for custom_rv_core with a unified memory model
module tb_custom_rv_core;
  logic        clk, rst_n;
  logic [31:0] iwb_adr_o, iwb_dat_i, dwb_adr_o, dwb_dat_o, dwb_dat_i, interrupts;
  logic        iwb_cyc_o, iwb_stb_o, iwb_ack_i, dwb_we_o, dwb_cyc_o, dwb_stb_o, dwb_ack_i, dwb_err_i;
  logic [3:0]  dwb_sel_o;

  logic [31:0] mem [0:4095];
  logic [31:0] fq[$];
  logic [31:0] d_adr[$], d_dat[$];
  logic [3:0]  d_sel[$];
  logic        d_we[$];
  logic        tohost_seen;
  int          n_vec, n_miss;

  custom_rv_core #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .iwb_adr_o(iwb_adr_o), .iwb_dat_i(iwb_dat_i), .iwb_cyc_o(iwb_cyc_o), .iwb_stb_o(iwb_stb_o),
    .iwb_ack_i(iwb_ack_i),
    .dwb_adr_o(dwb_adr_o), .dwb_dat_o(dwb_dat_o), .dwb_dat_i(dwb_dat_i), .dwb_we_o(dwb_we_o),
    .dwb_sel_o(dwb_sel_o), .dwb_cyc_o(dwb_cyc_o), .dwb_stb_o(dwb_stb_o), .dwb_ack_i(dwb_ack_i),
    .dwb_err_i(dwb_err_i), .interrupts(interrupts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Zero-wait memory; the 0x2000 page answers with a bus error
  assign iwb_ack_i = iwb_cyc_o & iwb_stb_o;
  assign iwb_dat_i = mem[iwb_adr_o[13:2]];
  assign dwb_err_i = dwb_cyc_o & dwb_stb_o & (dwb_adr_o[31:12] == 20'h00002);
  assign dwb_ack_i = dwb_cyc_o & dwb_stb_o & ~dwb_err_i;
  assign dwb_dat_i = mem[dwb_adr_o[13:2]];

  always @(posedge clk) begin
    if (dwb_ack_i && dwb_we_o)
      for (int b = 0; b < 4; b++)
        if (dwb_sel_o[b]) mem[dwb_adr_o[13:2]][8*b +: 8] <= dwb_dat_o[8*b +: 8];
  end

  always @(negedge clk) begin
    if (iwb_cyc_o && iwb_stb_o && iwb_ack_i) fq.push_back(iwb_adr_o);
    if (dwb_cyc_o && dwb_stb_o && (dwb_ack_i || dwb_err_i)) begin
      d_adr.push_back(dwb_adr_o); d_dat.push_back(dwb_dat_o);
      d_sel.push_back(dwb_sel_o); d_we.push_back(dwb_we_o);
      if (dwb_we_o && dwb_ack_i && dwb_adr_o == 32'h1000) tohost_seen = 1'b1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ei(input int imm, input int rs1, input int f3, input int rd, input int op);
    logic [31:0] im;
    im = imm;
    return {im[11:0], 5'(rs1), 3'(f3), 5'(rd), 7'(op)};
  endfunction
  function automatic logic [31:0] es(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] im;
    im = imm;
    return {im[11:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] eb(input int imm, input int rs2, input int rs1, input int f3);
    logic [31:0] im;
    im = imm;
    return {im[12], im[10:5], 5'(rs2), 5'(rs1), 3'(f3), im[4:1], im[11], 7'h63};
  endfunction
  function automatic logic [31:0] eu(input int imm20, input int rd);
    return {20'(imm20), 5'(rd), 7'h37};
  endfunction

  function automatic logic [31:0] fetch_after(input logic [31:0] a);
    for (int i = 0; i + 1 < fq.size(); i++) if (fq[i] == a) return fq[i + 1];
    return 32'hFFFF_FFFF;
  endfunction
  function automatic int store_idx(input logic [31:0] a);
    for (int i = 0; i < d_adr.size(); i++) if (d_adr[i] == a && d_we[i]) return i;
    return -1;
  endfunction
  function automatic int count_adr(input logic [31:0] a);
    int n;
    n = 0;
    for (int i = 0; i < d_adr.size(); i++) if (d_adr[i] == a) n++;
    return n;
  endfunction

  task automatic load_program();
    for (int i = 0; i < 4096; i++) mem[i] = 32'hDEAD_BEEF;
    mem['h00/4] = ei(5, 0, 0, 1, 'h13);        // addi x1,x0,5
    mem['h04/4] = ei(-7, 1, 0, 2, 'h13);       // addi x2,x1,-7
    mem['h08/4] = eu(1, 10);                   // lui x10,1
    mem['h0C/4] = es(4, 2, 10, 2);             // sw x2,4(x10)
    mem['h10/4] = eb(8, 1, 1, 0);              // beq x1,x1,+8
    mem['h14/4] = ei(1, 0, 0, 3, 'h13);        // addi x3,x0,1 (skipped)
    mem['h18/4] = eb(8, 1, 1, 1);              // bne x1,x1,+8
    mem['h1C/4] = ei(7, 0, 0, 4, 'h13);        // addi x4,x0,7
    mem['h20/4] = es(8, 3, 10, 2);             // sw x3,8(x10)
    mem['h24/4] = es(12, 4, 10, 2);            // sw x4,12(x10)
    mem['h28/4] = ei(-1, 0, 0, 5, 'h13);       // addi x5,x0,-1
    mem['h2C/4] = ei(1, 0, 0, 6, 'h13);        // addi x6,x0,1
    mem['h30/4] = eb(8, 6, 5, 6);              // bltu x5,x6,+8
    mem['h34/4] = ei(9, 0, 0, 7, 'h13);        // addi x7,x0,9
    mem['h38/4] = es(16, 7, 10, 2);            // sw x7,16(x10)
    mem['h3C/4] = ei('hAB, 0, 0, 8, 'h13);     // addi x8,x0,0xAB
    mem['h40/4] = es(3, 8, 10, 0);             // sb x8,3(x10)
    mem['h44/4] = ei(3, 10, 0, 9, 'h03);       // lb x9,3(x10)
    mem['h48/4] = ei(3, 10, 4, 11, 'h03);      // lbu x11,3(x10)
    mem['h4C/4] = es(20, 9, 10, 2);            // sw x9,20(x10)
    mem['h50/4] = es(24, 11, 10, 2);           // sw x11,24(x10)
    mem['h54/4] = ei('h100, 10, 0, 21, 'h13);  // addi x21,x10,0x100
    mem['h58/4] = ei('h100, 0, 0, 12, 'h13);   // addi x12,x0,0x100
    mem['h5C/4] = ei('h305, 12, 1, 0, 'h73);   // csrrw x0,mtvec,x12
    mem['h60/4] = ei(2, 10, 2, 13, 'h03);      // lw x13,2(x10) misaligned
    mem['h64/4] = 32'h0000_0073;               // ecall
    mem['h68/4] = 32'hFFFF_FFFF;               // illegal
    mem['h6C/4] = eu(2, 15);                   // lui x15,2
    mem['h70/4] = ei(0, 15, 2, 16, 'h03);      // lw x16,0(x15) bus error
    mem['h74/4] = ei(5, 0, 0, 0, 'h13);        // addi x0,x0,5
    mem['h78/4] = es(28, 0, 10, 2);            // sw x0,28(x10)
    mem['h7C/4] = ei(1, 0, 0, 14, 'h13);       // addi x14,x0,1
    mem['h80/4] = es(0, 14, 10, 2);            // sw x14,0(x10) tohost
    mem['h84/4] = 32'h0000_006F;               // jal x0,0
    // trap handler: log mcause/mepc/mtval at x21, step mepc past the faulting instruction
    mem['h100/4] = ei('h342, 0, 2, 20, 'h73);  // csrr x20,mcause
    mem['h104/4] = es(0, 20, 21, 2);
    mem['h108/4] = ei('h341, 0, 2, 20, 'h73);  // csrr x20,mepc
    mem['h10C/4] = es(4, 20, 21, 2);
    mem['h110/4] = ei('h343, 0, 2, 20, 'h73);  // csrr x20,mtval
    mem['h114/4] = es(8, 20, 21, 2);
    mem['h118/4] = ei(12, 21, 0, 21, 'h13);    // addi x21,x21,12
    mem['h11C/4] = ei('h341, 0, 2, 20, 'h73);  // csrr x20,mepc
    mem['h120/4] = ei(4, 20, 0, 20, 'h13);     // addi x20,x20,4
    mem['h124/4] = ei('h341, 20, 1, 0, 'h73);  // csrw mepc,x20
    mem['h128/4] = 32'h3020_0073;              // mret
  endtask

  logic [31:0] exp_log [0:11];
  initial begin
    int  idx;
    logic seen;
    n_vec = 0; n_miss = 0; tohost_seen = 1'b0;
    rst_n = 1'b0; interrupts = 32'd0;
    load_program();
    exp_log = '{32'd4, 32'h60, 32'h1002, 32'd11, 32'h64, 32'd0,
                32'd2, 32'h68, 32'hFFFF_FFFF, 32'd5, 32'h70, 32'h2000};
    repeat (3) @(negedge clk);
    check_eq("rst_iwb_cyc", {31'd0, iwb_cyc_o}, 32'd0);
    check_eq("rst_dwb_cyc", {31'd0, dwb_cyc_o}, 32'd0);
    check_eq("rst_dwb_we", {31'd0, dwb_we_o}, 32'd0);
    check_eq("rst_dwb_sel", {28'd0, dwb_sel_o}, 32'd0);
    check_eq("rst_dwb_adr", dwb_adr_o, 32'd0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      @(negedge clk);
      if (iwb_cyc_o) seen = 1'b1;
    end
    check_eq("first_fetch_seen", {31'd0, seen}, 32'd1);
    check_eq("first_fetch_adr", iwb_adr_o, 32'd0);
    check_eq("first_fetch_stb", {31'd0, iwb_stb_o}, 32'd1);

    for (int k = 0; k < 5000 && !tohost_seen; k++) @(negedge clk);
    check_eq("tohost_reached", {31'd0, tohost_seen}, 32'd1);
    repeat (4) @(negedge clk);

    check_eq("addi_neg", mem['h1004/4], 32'hFFFF_FFFE);
    check_eq("beq_skip", mem['h1008/4], 32'd0);
    check_eq("bne_fall", mem['h100C/4], 32'd7);
    check_eq("bltu_fall", mem['h1010/4], 32'd9);
    check_eq("lb_sext", mem['h1014/4], 32'hFFFF_FFAB);
    check_eq("lbu_zext", mem['h1018/4], 32'h0000_00AB);
    check_eq("x0_const", mem['h101C/4], 32'd0);
    check_eq("tohost_mem", mem['h1000/4], 32'd1);
    for (int i = 0; i < 12; i++) check_eq($sformatf("trap_log%0d", i), mem['h1100/4 + i], exp_log[i]);

    check_eq("beq_next_fetch", fetch_after(32'h10), 32'h18);
    check_eq("bne_next_fetch", fetch_after(32'h18), 32'h1C);
    check_eq("bltu_next_fetch", fetch_after(32'h30), 32'h34);
    check_eq("misal_next_fetch", fetch_after(32'h60), 32'h100);
    check_eq("ecall_next_fetch", fetch_after(32'h64), 32'h100);
    check_eq("mret_next_fetch", fetch_after(32'h128), 32'h64);
    check_eq("misal_no_bus", 32'(count_adr(32'h1002)), 32'd0);
    check_eq("err_one_cycle", 32'(count_adr(32'h2000)), 32'd1);

    idx = store_idx(32'h1003);
    check_eq("sb_found", {31'd0, idx >= 0}, 32'd1);
    if (idx >= 0) begin
      check_eq("sb_sel", {28'd0, d_sel[idx]}, 32'h8);
      check_eq("sb_dat", d_dat[idx], 32'hABAB_ABAB);
    end
    idx = store_idx(32'h1000);
    check_eq("sw_found", {31'd0, idx >= 0}, 32'd1);
    if (idx >= 0) begin
      check_eq("sw_sel", {28'd0, d_sel[idx]}, 32'hF);
      check_eq("sw_dat", d_dat[idx], 32'd1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
